// File: rtl/rtp_pkg.sv
// Shared constants, FSM encoding and helpers for the RTP depacketizer.
package rtp_pkg;

    localparam int         RTP_HEADER_LENGTH = 12;
    localparam logic [7:0] RTP_BYTE0         = 8'h80;
    // Smallest packet that still carries one full 16-bit sample.
    localparam int         RTP_MIN_PKT_LEN   = RTP_HEADER_LENGTH + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } rtp_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rtp_depacketizer_if.sv
// UDP byte stream in, PCM sample request/response and statistics out.
interface rtp_depacketizer_if;

    logic               udp_rec_data_valid;
    logic [7:0]         udp_rec_rdata;
    logic [15:0]        udp_rec_data_length;
    logic               wav_rden;
    logic signed [15:0] wav_out_data;
    logic               wav_out_valid;
    logic               underrun;
    logic [15:0]        pkt_ok_cnt;
    logic [15:0]        pkt_drop_cnt;
    logic [15:0]        seq_gap_cnt;

    modport master (
        output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, wav_rden,
        input  wav_out_data, wav_out_valid, underrun,
        input  pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt
    );

    modport slave (
        input  udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, wav_rden,
        output wav_out_data, wav_out_valid, underrun,
        output pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt
    );

endinterface

// File: rtl/rtp_rx_fifo.sv
// Sample FIFO with tentative writes: only samples below the commit pointer
// are visible to the reader; rollback discards everything past it.
module rtp_rx_fifo #(
    parameter int DEPTH = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en_i,
    input  logic [15:0]               wr_data_i,
    input  logic                      commit_i,
    input  logic                      rollback_i,
    input  logic                      rd_en_i,
    output logic [15:0]               rd_data_o,
    output logic [$clog2(DEPTH):0]    cmt_count_o,
    output logic                      full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_q, cmt_q, rd_q;

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            cmt_q <= '0;
            rd_q  <= '0;
        end else begin
            if (rollback_i)   wr_q <= cmt_q;
            else if (wr_en_i) wr_q <= wr_q + PW'(1);
            if (commit_i)     cmt_q <= wr_q;
            if (rd_en_i)      rd_q <= rd_q + PW'(1);
        end
    end

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem[wr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o   = mem[rd_q[AW-1:0]];
    assign cmt_count_o = cmt_q - rd_q;
    assign full_o      = ((wr_q - rd_q) == PW'(DEPTH));

endmodule

// File: rtl/rtp_depacketizer.sv
// RTP-over-UDP depacketizer: validates the fixed header, unpacks big-endian
// 16-bit PCM into a FIFO, commits whole packets only, serves DAC requests.
module rtp_depacketizer
    import rtp_pkg::*;
#(
    parameter logic [31:0] EXP_SSRC   = 32'h12345678,
    parameter logic [6:0]  EXP_PT     = 7'd0,
    parameter int          FIFO_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               rst,
    rtp_depacketizer_if.slave  bus
);

    localparam int FAW = $clog2(FIFO_DEPTH);

    rtp_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d, len_q, len_d;
    logic        bad_q, bad_d, byte_bad;
    logic [15:0] seq_q, seq_d, last_seq_q, last_seq_d;
    logic        have_seq_q, have_seq_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] ok_q, ok_d, drop_q, drop_d, gap_q, gap_d;

    logic        wr_en, commit, rollback, fifo_full, rd_go;
    logic [15:0] rd_data;
    logic [FAW:0] cmt_cnt;

    logic signed [15:0] wav_data_q;
    logic               wav_vld_q, underrun_q;

    logic       vld;
    logic [7:0] din;
    assign vld = bus.udp_rec_data_valid;
    assign din = bus.udp_rec_rdata;

    // Packet FSM: cnt counts bytes already consumed for the current packet.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        bad_d      = bad_q;
        seq_d      = seq_q;
        hi_d       = hi_q;
        last_seq_d = last_seq_q;
        have_seq_d = have_seq_q;
        ok_d       = ok_q;
        drop_d     = drop_q;
        gap_d      = gap_q;
        wr_en      = 1'b0;
        commit     = 1'b0;
        rollback   = 1'b0;
        byte_bad   = 1'b0;
        case (state_q)
            IDLE: if (vld) begin
                len_d = bus.udp_rec_data_length;
                cnt_d = 16'd1;
                bad_d = (din != RTP_BYTE0);
                if (bus.udp_rec_data_length < 16'(RTP_MIN_PKT_LEN)) begin
                    state_d = DROP;
                    drop_d  = sat_inc(drop_q);
                end else begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (!vld) begin
                    state_d = IDLE;
                    drop_d  = sat_inc(drop_q);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    case (cnt_q)
                        16'd1:   byte_bad = (din[6:0] != EXP_PT);
                        16'd2:   seq_d[15:8] = din;
                        16'd3:   seq_d[7:0]  = din;
                        16'd8:   byte_bad = (din != EXP_SSRC[31:24]);
                        16'd9:   byte_bad = (din != EXP_SSRC[23:16]);
                        16'd10:  byte_bad = (din != EXP_SSRC[15:8]);
                        16'd11:  byte_bad = (din != EXP_SSRC[7:0]);
                        default: byte_bad = 1'b0;
                    endcase
                    bad_d = bad_q | byte_bad;
                    if (cnt_q == 16'(RTP_HEADER_LENGTH - 1)) begin
                        if (bad_d) begin
                            state_d = DROP;
                            drop_d  = sat_inc(drop_q);
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (cnt_q == len_q) begin
                    commit     = 1'b1;
                    ok_d       = sat_inc(ok_q);
                    if (have_seq_q && (seq_q != last_seq_q + 16'd1)) gap_d = sat_inc(gap_q);
                    last_seq_d = seq_q;
                    have_seq_d = 1'b1;
                    state_d    = IDLE;
                end else if (!vld) begin
                    rollback = 1'b1;
                    drop_d   = sat_inc(drop_q);
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    // Header length is even, so byte parity equals payload parity.
                    if (!cnt_q[0]) begin
                        hi_d = din;
                    end else if (fifo_full) begin
                        rollback = 1'b1;
                        drop_d   = sat_inc(drop_q);
                        state_d  = DROP;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!vld || cnt_q >= len_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q + 16'd1 >= len_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and packet-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            bad_q      <= 1'b0;
            seq_q      <= '0;
            hi_q       <= '0;
            last_seq_q <= '0;
            have_seq_q <= 1'b0;
            ok_q       <= '0;
            drop_q     <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            bad_q      <= bad_d;
            seq_q      <= seq_d;
            hi_q       <= hi_d;
            last_seq_q <= last_seq_d;
            have_seq_q <= have_seq_d;
            ok_q       <= ok_d;
            drop_q     <= drop_d;
            gap_q      <= gap_d;
        end
    end

    rtp_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (wr_en),
        .wr_data_i   ({hi_q, din}),
        .commit_i    (commit),
        .rollback_i  (rollback),
        .rd_en_i     (rd_go),
        .rd_data_o   (rd_data),
        .cmt_count_o (cmt_cnt),
        .full_o      (fifo_full)
    );

    // Occupancy seen here is pre-commit, so a same-cycle commit is not readable yet.
    assign rd_go = bus.wav_rden && (cmt_cnt != '0);

    // One-cycle request response; data holds between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            wav_data_q <= '0;
            wav_vld_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wav_vld_q  <= rd_go;
            underrun_q <= bus.wav_rden && !rd_go;
            if (rd_go)             wav_data_q <= rd_data;
            else if (bus.wav_rden) wav_data_q <= '0;
        end
    end

    assign bus.wav_out_data  = wav_data_q;
    assign bus.wav_out_valid = wav_vld_q;
    assign bus.underrun      = underrun_q;
    assign bus.pkt_ok_cnt    = ok_q;
    assign bus.pkt_drop_cnt  = drop_q;
    assign bus.seq_gap_cnt   = gap_q;

endmodule

// File: tb/tb_rtp_depacketizer.sv
// Self-checking bench for rtp_depacketizer: directed scenarios plus random
// packets, checked against a queue-based reference of committed samples.
module tb_rtp_depacketizer;
    import rtp_pkg::*;

    localparam logic [31:0] SSRC  = 32'h12345678;
    localparam logic [6:0]  PT    = 7'd0;
    localparam int          DEPTH = 1024;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    rtp_depacketizer_if bus();

    rtp_depacketizer #(.EXP_SSRC(SSRC), .EXP_PT(PT), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_chk, n_err;
    int          mq[$];          // samples the reader may legally see, in order
    int          m_ok, m_drop, m_gap, m_last;
    bit          m_have;
    int          last_rd;
    logic [15:0] pl[$];          // payload samples of the next packet

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.udp_rec_data_valid  = 1'b0;
        bus.udp_rec_rdata       = 8'h00;
        bus.udp_rec_data_length = 16'h0000;
        bus.wav_rden            = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        mq.delete();
        m_ok = 0; m_drop = 0; m_gap = 0; m_last = 0; m_have = 1'b0; last_rd = 0;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".ok"},   32'(bus.pkt_ok_cnt),   32'(m_ok));
        chk({tag, ".drop"}, 32'(bus.pkt_drop_cnt), 32'(m_drop));
        chk({tag, ".gap"},  32'(bus.seq_gap_cnt),  32'(m_gap));
    endtask

    task automatic do_read();
        int exp;
        bit have;
        have = (mq.size() != 0);
        bus.wav_rden = 1'b1;
        tick(1);
        bus.wav_rden = 1'b0;
        if (have) begin
            exp = mq.pop_front();
            last_rd = exp;
            chk("rd.valid", 32'(bus.wav_out_valid), 32'd1);
            chk("rd.unr",   32'(bus.underrun),      32'd0);
            chk("rd.data",  {16'h0, bus.wav_out_data}, 32'(exp));
        end else begin
            last_rd = 0;
            chk("unr.valid", 32'(bus.wav_out_valid), 32'd0);
            chk("unr.flag",  32'(bus.underrun),      32'd1);
            chk("unr.data",  {16'h0, bus.wav_out_data}, 32'd0);
        end
    endtask

    task automatic mk_pl(input int n, input bit ramp, input int base);
        pl.delete();
        for (int i = 0; i < n; i++)
            pl.push_back(ramp ? 16'(base + i) : 16'($urandom));
    endtask

    // Drive nsend bytes of a packet declaring length len, then apply the
    // acceptance rules to the reference model.
    task automatic send_pkt(input int len, input int nsend, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [15:0] seq,
                            input logic [31:0] ssrc, input bit rd_at_commit);
        logic [7:0]  hdr [12];
        logic [7:0]  b;
        logic [15:0] s;
        int          k, nsamp;
        bit          bad, acc;
        hdr[0] = b0; hdr[1] = b1; hdr[2] = seq[15:8]; hdr[3] = seq[7:0];
        for (int i = 4; i < 8; i++) hdr[i] = 8'($urandom);
        hdr[8] = ssrc[31:24]; hdr[9] = ssrc[23:16]; hdr[10] = ssrc[15:8]; hdr[11] = ssrc[7:0];
        for (int i = 0; i < nsend; i++) begin
            if (i < 12) begin
                b = hdr[i];
            end else begin
                k = i - 12;
                if (k / 2 < pl.size()) begin
                    s = pl[k / 2];
                    b = (k % 2 == 0) ? s[15:8] : s[7:0];
                end else begin
                    b = 8'hA5;
                end
            end
            bus.udp_rec_data_valid  = 1'b1;
            bus.udp_rec_rdata       = b;
            bus.udp_rec_data_length = 16'(len);
            tick(1);
        end
        bus.udp_rec_data_valid = 1'b0;
        bus.udp_rec_rdata      = 8'h00;
        nsamp = (len >= 14) ? (len - 12) / 2 : 0;
        bad   = (b0 != RTP_BYTE0) || (b1[6:0] != PT) || (ssrc != SSRC);
        acc   = (len >= 14) && (nsend >= len) && !bad && (mq.size() + nsamp <= DEPTH);
        // A read on the commit cycle sees the occupancy before this packet.
        if (rd_at_commit) do_read();
        if (acc) begin
            for (int i = 0; i < nsamp; i++) mq.push_back(int'(pl[i]));
            m_ok++;
            if (m_have && int'(seq) != (m_last + 1) % 65536) m_gap++;
            m_have = 1'b1;
            m_last = int'(seq);
        end else begin
            m_drop++;
        end
        tick(3);
    endtask

    task automatic drain();
        while (mq.size() > 0) do_read();
        do_read();
    endtask

    int          len, nsend, sel, nrd;
    logic [7:0]  b0, b1;
    logic [31:0] ss;
    logic [15:0] sq;

    initial begin
        n_chk = 0;
        n_err = 0;

        // Reset state.
        do_reset();
        chk_cnt("rst");
        chk("rst.valid", 32'(bus.wav_out_valid), 32'd0);
        chk("rst.unr",   32'(bus.underrun),      32'd0);
        chk("rst.data",  {16'h0, bus.wav_out_data}, 32'd0);

        // Good 972-byte packet, ramp 0x0001..0x01E0.
        mk_pl(480, 1'b1, 1);
        send_pkt(972, 972, 8'h80, 8'h00, 16'd5, SSRC, 1'b0);
        chk_cnt("good");
        while (mq.size() > 0) do_read();
        chk("ramp.last", 32'(last_rd), 32'h01E0);
        tick(3);
        chk("hold.data",  {16'h0, bus.wav_out_data}, 32'(last_rd));
        chk("hold.valid", 32'(bus.wav_out_valid), 32'd0);
        chk("hold.unr",   32'(bus.underrun),      32'd0);
        do_read();

        // Wrong SSRC.
        do_reset();
        mk_pl(480, 1'b1, 1);
        send_pkt(972, 972, 8'h80, 8'h00, 16'd1, 32'hDEADBEEF, 1'b0);
        chk_cnt("ssrc");
        do_read();

        // Truncation after byte 500 leaves an earlier commit intact.
        do_reset();
        mk_pl(4, 1'b1, 16'h0A00);
        send_pkt(20, 20, 8'h80, 8'h80, 16'd9, SSRC, 1'b0);
        mk_pl(480, 1'b1, 16'h2000);
        send_pkt(972, 500, 8'h80, 8'h00, 16'd10, SSRC, 1'b0);
        chk_cnt("trunc");
        drain();

        // Sequence wrap is not a gap; 0000 -> 0002 is.
        do_reset();
        mk_pl(2, 1'b1, 7);
        send_pkt(16, 16, 8'h80, 8'h00, 16'hFFFF, SSRC, 1'b0);
        send_pkt(16, 16, 8'h80, 8'h00, 16'h0000, SSRC, 1'b0);
        send_pkt(16, 16, 8'h80, 8'h00, 16'h0002, SSRC, 1'b0);
        chk_cnt("seq");
        drain();

        // 900 committed samples, then a 480-sample packet overflows.
        do_reset();
        mk_pl(450, 1'b1, 1);
        send_pkt(912, 912, 8'h80, 8'h00, 16'd1, SSRC, 1'b0);
        mk_pl(450, 1'b1, 451);
        send_pkt(912, 912, 8'h80, 8'h00, 16'd2, SSRC, 1'b0);
        mk_pl(480, 1'b1, 16'h8000);
        send_pkt(972, 972, 8'h80, 8'h00, 16'd3, SSRC, 1'b0);
        chk_cnt("ovf");
        chk("ovf.depth", 32'(mq.size()), 32'd900);
        drain();

        // Read on the commit cycle of an empty FIFO underruns; next read gets sample 0.
        do_reset();
        mk_pl(8, 1'b1, 16'h0101);
        send_pkt(28, 28, 8'h80, 8'h00, 16'd77, SSRC, 1'b1);
        chk_cnt("rdcmt");
        do_read();
        chk("rdcmt.first", 32'(last_rd), 32'h0101);
        drain();

        // Reset in the middle of a packet abandons it without counting.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            bus.udp_rec_data_valid  = 1'b1;
            bus.udp_rec_rdata       = (i == 0) ? 8'h80 : 8'h00;
            bus.udp_rec_data_length = 16'd200;
            tick(1);
        end
        do_reset();
        chk_cnt("midrst");
        mk_pl(3, 1'b0, 0);
        send_pkt(18, 18, 8'h80, 8'h00, 16'd4, SSRC, 1'b0);
        chk_cnt("midrst.pkt");
        drain();

        // Random packets: short, truncated, bad header fields, seq jumps.
        do_reset();
        for (int p = 0; p < 60; p++) begin
            sel   = $urandom_range(0, 9);
            len   = (sel == 0) ? $urandom_range(0, 13) : $urandom_range(14, 120);
            nsend = (sel == 1) ? $urandom_range(1, len - 1) : len;
            if (nsend < 1) nsend = 1;
            b0 = (sel == 2) ? 8'h90 : 8'h80;
            b1 = {1'($urandom), (sel == 3) ? 7'd8 : PT};
            ss = (sel == 4) ? (SSRC ^ (32'h1 << $urandom_range(0, 31))) : SSRC;
            sq = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(m_last + 1);
            mk_pl((len >= 14) ? (len - 12) / 2 : 0, 1'b0, 0);
            send_pkt(len, nsend, b0, b1, sq, ss, 1'b0);
            chk_cnt("rnd");
            nrd = $urandom_range(0, 6);
            for (int r = 0; r < nrd; r++) do_read();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
